// File: rtl/traffic_control_prog_if.sv
// Signal bundle for traffic_control_prog: error input, pedestrian requests,
// configuration write port and the registered lamp/walk/phase outputs.
interface traffic_control_prog_if #(
  parameter int CNT_W = 8
);
  logic             ERR;
  logic             PA;
  logic             PB;
  logic             cfg_we;
  logic [1:0]       cfg_addr;
  logic [CNT_W-1:0] cfg_data;
  logic [2:0]       L_A;
  logic [2:0]       L_B;
  logic             RA;
  logic             RB;
  logic [2:0]       phase;

  modport master (
    output ERR, PA, PB, cfg_we, cfg_addr, cfg_data,
    input  L_A, L_B, RA, RB, phase
  );

  modport slave (
    input  ERR, PA, PB, cfg_we, cfg_addr, cfg_data,
    output L_A, L_B, RA, RB, phase
  );
endinterface

// File: rtl/traffic_control_prog.sv
// Two-road intersection controller with run-time programmable phase durations.
// Optional macro TRAFFIC_EARLY_GREEN_EN: early green termination on a pending request.
module traffic_control_prog #(
  parameter int CNT_W       = 8,
  parameter int D_GREEN_RST = 8,
  parameter int D_TURN_RST  = 3,
  parameter int D_YEL_RST   = 3,
  parameter int D_PED_RST   = 6,
  parameter int MIN_GREEN   = 4
) (
  input logic                   CLK,
  input logic                   reset,
  traffic_control_prog_if.slave bus
);

  typedef enum logic [2:0] {
    S0_PED = 3'd0,
    S1     = 3'd1,
    S2     = 3'd2,
    S3     = 3'd3,
    S4     = 3'd4,
    S5     = 3'd5,
    S6     = 3'd6,
    S7_ERR = 3'd7
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_tick;
  logic [CNT_W-1:0] r_shadow;
  logic [CNT_W-1:0] r_d_green;
  logic [CNT_W-1:0] r_d_turn;
  logic [CNT_W-1:0] r_d_yel;
  logic [CNT_W-1:0] r_d_ped;
  logic [CNT_W-1:0] w_dur_raw;
  logic [CNT_W-1:0] w_dur;
  logic             r_pa_req;
  logic             r_pb_req;
  logic             r_served_a;
  logic             r_served_b;
  logic             r_ret_s4;
  logic             w_pending;
  logic             w_done;
  logic             w_early;
  logic             w_entry;
  logic [2:0]       w_la;
  logic [2:0]       w_lb;
  logic [2:0]       r_la;
  logic [2:0]       r_lb;
  logic             r_ra;
  logic             r_rb;
  logic [2:0]       r_phase;

  assign w_pending = r_pa_req | r_pb_req;
  assign w_done    = (r_tick == (r_shadow - {{(CNT_W-1){1'b0}}, 1'b1}));
  assign w_entry   = (w_next != r_state);

`ifdef TRAFFIC_EARLY_GREEN_EN
  assign w_early = ((r_state == S1) || (r_state == S4)) && w_pending &&
                   (r_tick >= CNT_W'(MIN_GREEN - 1));
`else
  assign w_early = 1'b0;
`endif

  // Next-state decision; a pending request only diverts the S3/S6 exits into S0.
  always_comb begin
    w_next = r_state;
    if (w_done || w_early) begin
      case (r_state)
        S0_PED:  w_next = r_ret_s4 ? S4 : S1;
        S1:      w_next = S2;
        S2:      w_next = S3;
        S3:      w_next = w_pending ? S0_PED : S4;
        S4:      w_next = S5;
        S5:      w_next = S6;
        S6:      w_next = w_pending ? S0_PED : S1;
        S7_ERR:  w_next = S0_PED;
        default: w_next = S7_ERR;
      endcase
    end else begin
      w_next = r_state;
    end
  end

  // Duration loaded into the shadow on entry to w_next; zero is stretched to one.
  always_comb begin
    w_dur_raw = {{(CNT_W-1){1'b0}}, 1'b1};
    case (w_next)
      S0_PED:  w_dur_raw = r_d_ped;
      S1, S4:  w_dur_raw = r_d_green;
      S2, S5:  w_dur_raw = r_d_turn;
      S3, S6:  w_dur_raw = r_d_yel;
      default: w_dur_raw = {{(CNT_W-1){1'b0}}, 1'b1};
    endcase
    if (w_dur_raw == {CNT_W{1'b0}}) begin
      w_dur = {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      w_dur = w_dur_raw;
    end
  end

  // Lamp decode of the current state, registered below so outputs lag by a cycle.
  always_comb begin
    w_la = 3'b000;
    w_lb = 3'b000;
    case (r_state)
      S0_PED:  begin w_la = 3'b111; w_lb = 3'b111; end
      S1:      begin w_la = 3'b110; w_lb = 3'b011; end
      S2:      begin w_la = 3'b101; w_lb = 3'b010; end
      S3:      begin w_la = 3'b100; w_lb = 3'b010; end
      S4:      begin w_la = 3'b011; w_lb = 3'b110; end
      S5:      begin w_la = 3'b010; w_lb = 3'b101; end
      S6:      begin w_la = 3'b010; w_lb = 3'b100; end
      default: begin w_la = 3'b000; w_lb = 3'b000; end
    endcase
  end

  // State, timing, request and output registers; ERR outranks reset and keeps config.
  always_ff @(posedge CLK) begin
    if (bus.ERR || reset) begin
      r_state    <= S7_ERR;
      r_tick     <= {CNT_W{1'b0}};
      r_shadow   <= {{(CNT_W-1){1'b0}}, 1'b1};
      r_pa_req   <= 1'b0;
      r_pb_req   <= 1'b0;
      r_served_a <= 1'b0;
      r_served_b <= 1'b0;
      r_ret_s4   <= 1'b0;
      r_la       <= 3'b000;
      r_lb       <= 3'b000;
      r_ra       <= 1'b0;
      r_rb       <= 1'b0;
      r_phase    <= 3'd7;
      if (!bus.ERR) begin
        r_d_green <= CNT_W'(D_GREEN_RST);
        r_d_turn  <= CNT_W'(D_TURN_RST);
        r_d_yel   <= CNT_W'(D_YEL_RST);
        r_d_ped   <= CNT_W'(D_PED_RST);
      end
    end else begin
      if (bus.cfg_we) begin
        case (bus.cfg_addr)
          2'd0:    r_d_green <= bus.cfg_data;
          2'd1:    r_d_turn  <= bus.cfg_data;
          2'd2:    r_d_yel   <= bus.cfg_data;
          default: r_d_ped   <= bus.cfg_data;
        endcase
      end
      r_state <= w_next;
      if (w_entry) begin
        r_tick   <= {CNT_W{1'b0}};
        r_shadow <= w_dur;
      end else begin
        r_tick <= r_tick + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (w_entry && (w_next == S0_PED)) begin
        r_pa_req <= 1'b0;
        r_pb_req <= 1'b0;
        r_ret_s4 <= (r_state == S3);
        if (r_state == S7_ERR) begin
          r_served_a <= 1'b1;
          r_served_b <= 1'b1;
        end else begin
          r_served_a <= r_pa_req | bus.PA;
          r_served_b <= r_pb_req | bus.PB;
        end
      end else if ((r_state != S0_PED) && (r_state != S7_ERR)) begin
        r_pa_req <= r_pa_req | bus.PA;
        r_pb_req <= r_pb_req | bus.PB;
      end
      r_la    <= w_la;
      r_lb    <= w_lb;
      r_ra    <= (r_state == S0_PED) & r_served_a;
      r_rb    <= (r_state == S0_PED) & r_served_b;
      r_phase <= r_state;
    end
  end

  assign bus.L_A   = r_la;
  assign bus.L_B   = r_lb;
  assign bus.RA    = r_ra;
  assign bus.RB    = r_rb;
  assign bus.phase = r_phase;

endmodule

// File: doc/traffic_control_prog.md
Name: traffic_control_prog

Overview:
- Parametrised, run-time-programmable two-road intersection controller: road A and road B, each with a pedestrian-request channel.
- Same seven-phase signal cycle, error/flash mode and pedestrian service semantics as the current traffic FSM.
- Phase durations are no longer fixed constants. They come from four configuration registers loaded through a simple write port and sampled at phase entry.
- Sits between the pedestrian-button synchronisers and the lamp drivers.

Parameters:
- CNT_W, 8: width of duration registers and tick counter.
- D_GREEN_RST, 8: reset value of green duration, used by S1 and S4.
- D_TURN_RST, 3: reset value of turn duration, used by S2 and S5.
- D_YEL_RST, 3: reset value of yellow duration, used by S3 and S6.
- D_PED_RST, 6: reset value of pedestrian duration, used by S0.
- MIN_GREEN, 4: minimum green ticks before early termination; used only with the optional feature.

Ports:
- CLK, in, 1: clock; all logic on rising edge.
- reset, in, 1: synchronous, active-high reset.
- ERR, in, 1: synchronous, active-high; highest priority, overrides reset.
- PA, in, 1: pedestrian request, road A; active high.
- PB, in, 1: pedestrian request, road B; active high.
- cfg_we, in, 1: configuration write strobe.
- cfg_addr, in, 2: register select. 0 = green, 1 = turn, 2 = yellow, 3 = ped.
- cfg_data, in, CNT_W: value to write.
- L_A, out, 3: road A lamp code.
- L_B, out, 3: road B lamp code.
- RA, out, 1: road A pedestrian walk.
- RB, out, 1: road B walk.
- phase, out, 3: current state index, 0–7, registered.

Behaviour:
- States and lamp codes (L_A / L_B):
  - S0 PED: 111 / 111.
  - S1: 110 / 011.
  - S2: 101 / 010.
  - S3: 100 / 010.
  - S4: 011 / 110.
  - S5: 010 / 101.
  - S6: 010 / 100.
  - S7 ERR: 000 / 000.
  - Illegal state: go to S7.
- Normal cycle: S1→S2→S3→S4→S5→S6→S1.
  - On leaving S3: if any request is pending, go to S0, then return to S4.
  - On leaving S6: if any request is pending, go to S0, then return to S1.
  - Leaving S7 (ERR and reset both low): always go to S0, then S1.
- Duration registers:
  - Reset (not ERR) loads the *_RST values.
  - A cfg_we write updates the addressed register on the next edge. Writes are ignored while reset or ERR is high.
  - On each phase entry, the phase's duration is copied into a shadow register. Writes made during a phase take effect from the next entry of the affected phase.
  - Programmed value 0 is treated as 1.
- Tick counter:
  - Cleared on phase entry.
  - Phase exits on the cycle where tick == shadow-1, so a phase lasts exactly max(dur,1) cycles.
  - S7 lasts 1 cycle after ERR/reset drop.
- Requests:
  - pa_req/pb_req latch PA/PB only in S1–S6.
  - Both are cleared on entry to S0; at that moment they are captured as served_a/served_b.
  - PA/PB are ignored in S0 and S7.
  - A press on the same cycle as the S3/S6 exit decision is latched, but does not affect that decision.
- Walk outputs:
  - RA = served_a and RB = served_b during S0.
  - S0 entered from S7: both are served.
  - RA and RB are 0 in all other phases.
- Outputs are registered and lag state by one cycle. phase shows the state of the previous cycle, consistent with L_A/L_B.
- ERR or reset:
  - Next edge: state = S7, tick = 0, requests cleared, served flags cleared.
  - L_A = L_B = 000, RA = RB = 0, phase = 7.
  - ERR does not alter configuration registers; reset restores defaults.
  - Both behave the same mid-phase.

Optional Feature:
- TRAFFIC_EARLY_GREEN_EN defined: in S1 or S4, if a request is pending and tick >= MIN_GREEN-1, the phase exits at the next edge instead of running full duration.
  - The normal S2/S3 (or S5/S6) sequence follows, then S0.
  - If MIN_GREEN >= green duration, there is no effect.
- Undefined: green always runs its full programmed duration; MIN_GREEN is unused.

Test Plan:
- Reset 3 cycles, then release, defaults:
  - phase sequence 7 (1 cycle), 0 (6), 1 (8), 2 (3), 3 (3), 4 (8).
  - RA = RB = 1 for all 6 S0 cycles.
  - Lamps match the state table, one cycle late.
- PA pulse 1 cycle mid-S2: S3 exits to S0 with RA = 1, RB = 0 for 6 cycles, then S4. A PB press during S0 is ignored.
- Write green = 12 via cfg_addr 0 mid-S1: current S1 still 8 cycles; next S4 is 12 cycles.
- Write ped = 0: S0 lasts 1 cycle. Write turn = 20, then ERR:
  - ERR gives 000/000 and RA = RB = 0.
  - After ERR drops, durations are retained (turn = 20), not reset.
- ERR and reset high together for 2 cycles, then reset only: stays in S7; all config registers return to defaults.
- With TRAFFIC_EARLY_GREEN_EN, MIN_GREEN = 4: PB asserted at S1 tick 1 → S1 lasts 4 cycles, then S2, S3, S0 with RB = 1. Without the macro, S1 lasts 8 cycles.
